// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between a store unit and a single
// main-memory write port. Stores are queued in a circular FIFO and
// retired one per cycle whenever the memory port is free. Pending 16-bit
// loads can probe the queue for byte overlap.

`ifndef ALEN
`define ALEN 16
`endif
`ifndef XLEN
`define XLEN 16
`endif

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [`ALEN-1:0]  st_addr,
    input  logic [`XLEN-1:0]  st_data,
    input  logic [1:0]        st_be,
    input  logic              drain_en,
    output logic [`ALEN-1:0]  mem_wr_addr,
    output logic [`XLEN-1:0]  mem_wr_data,
    output logic [1:0]        mem_wr_en,
    input  logic [`ALEN-1:0]  ld_addr,
    output logic              ld_hazard,
    output logic              empty
);

    localparam int AL = `ALEN;
    localparam int XL = `XLEN;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AL-1:0]  addr_q  [DEPTH];
    logic [XL-1:0]  data_q  [DEPTH];
    logic [1:0]     be_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;

    logic           enq;
    logic           deq;
    logic [AL-1:0]  ld_next;

    // Handshake status and the push/pop decisions for this cycle.
    always_comb begin
        empty    = (count == '0);
        st_ready = (count < FULL_CNT);
        // Zero-byte-enable stores are acknowledged but never occupy a slot.
        enq      = st_valid && st_ready && (st_be != 2'b00);
        deq      = drain_en && !empty;
    end

    // Head entry presented to memory; outputs forced to zero when nothing is queued.
    always_comb begin
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_en   = 2'b00;
        if (!empty) begin
            mem_wr_addr = addr_q[head];
            mem_wr_data = data_q[head];
        end
        if (deq) begin
            mem_wr_en = be_q[head];
        end
    end

    // Byte-overlap check of the load window {ld_addr, ld_addr+1} against every queued entry.
    // The store being accepted this cycle is not yet in valid_q, so it is naturally excluded.
    always_comb begin
        logic [AL-1:0] byte_hi;
        logic          hit_lo;
        logic          hit_hi;
        ld_hazard = 1'b0;
        ld_next   = ld_addr + AL'(1);
        byte_hi   = '0;
        hit_lo    = 1'b0;
        hit_hi    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            byte_hi = addr_q[i] + AL'(1);
            hit_lo  = be_q[i][0] && ((addr_q[i] == ld_addr) || (addr_q[i] == ld_next));
            hit_hi  = be_q[i][1] && ((byte_hi == ld_addr) || (byte_hi == ld_next));
            if (valid_q[i] && (hit_lo || hit_hi)) begin
                ld_hazard = 1'b1;
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: write at tail on accept, invalidate at head on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= 2'b00;
            end
        end else begin
            // Head and tail only coincide when empty or full, where one of
            // deq/enq is already blocked, so the two writes never collide.
            if (deq) begin
                valid_q[head] <= 1'b0;
            end
            if (enq) begin
                valid_q[tail] <= 1'b1;
                addr_q[tail]  <= st_addr;
                data_q[tail]  <= st_data;
                be_q[tail]    <= st_be;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH = 4, 16-bit addr/data).

`ifndef ALEN
`define ALEN 16
`endif
`ifndef XLEN
`define XLEN 16
`endif

module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic [1:0]  st_be;
    logic        drain_en;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic [1:0]  mem_wr_en;
    logic [15:0] ld_addr;
    logic        ld_hazard;
    logic        empty;

    int errors = 0;
    int checks = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .drain_en    (drain_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        dr;
        logic [15:0] ld;
        logic        e_ready;
        logic        e_empty;
        logic [1:0]  e_wr_en;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic        e_haz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic emp,
                              input logic [1:0] wen, input logic [15:0] wa,
                              input logic [15:0] wd, input logic hz);
        check({tag, ".st_ready"},    32'(st_ready),    32'(rdy));
        check({tag, ".empty"},       32'(empty),       32'(emp));
        check({tag, ".mem_wr_en"},   32'(mem_wr_en),   32'(wen));
        check({tag, ".mem_wr_addr"}, 32'(mem_wr_addr), 32'(wa));
        check({tag, ".mem_wr_data"}, 32'(mem_wr_data), 32'(wd));
        check({tag, ".ld_hazard"},   32'(ld_hazard),   32'(hz));
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic dr, input logic [15:0] ld);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        drain_en = dr;
        ld_addr  = ld;
    endtask

    initial begin
        //            v  addr      data      be     dr  ld        rdy emp wen    waddr     wdata     hz
        // single store, one-cycle latency, retiring head still hazards
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b1, 16'h0010, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0010, 1, 0, 2'b11, 16'h0010, 16'hBEEF, 1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0010, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        // hazard windows including address wrap
        vecs.push_back('{1'b1, 16'h0021, 16'h1234, 2'b01, 1'b0, 16'h0020, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0020, 1, 0, 2'b00, 16'h0021, 16'h1234, 1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0022, 1, 0, 2'b00, 16'h0021, 16'h1234, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0021, 1, 0, 2'b00, 16'h0021, 16'h1234, 1});
        vecs.push_back('{1'b1, 16'hFFFF, 16'hAB00, 2'b10, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0021, 16'h1234, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0021, 16'h1234, 1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'hFFFE, 1, 0, 2'b00, 16'h0021, 16'h1234, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 0, 2'b01, 16'h0021, 16'h1234, 1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 0, 2'b10, 16'hFFFF, 16'hAB00, 1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        // zero byte-enable store is swallowed; idle inputs ignored
        vecs.push_back('{1'b1, 16'h0040, 16'h5555, 2'b00, 1'b1, 16'h0040, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 16'h0041, 16'h6666, 2'b11, 1'b1, 16'h0040, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0040, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        // fill to DEPTH, held fifth store refused, ordered drain
        vecs.push_back('{1'b1, 16'h0100, 16'h1111, 2'b11, 1'b0, 16'h0000, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 16'h0102, 16'h2222, 2'b11, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0100, 16'h1111, 0});
        vecs.push_back('{1'b1, 16'h0104, 16'h3333, 2'b01, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0100, 16'h1111, 0});
        vecs.push_back('{1'b1, 16'h0106, 16'h4444, 2'b10, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0100, 16'h1111, 0});
        vecs.push_back('{1'b1, 16'h0108, 16'h5555, 2'b11, 1'b0, 16'h0108, 0, 0, 2'b00, 16'h0100, 16'h1111, 0});
        vecs.push_back('{1'b1, 16'h0108, 16'h5555, 2'b11, 1'b1, 16'h0108, 0, 0, 2'b11, 16'h0100, 16'h1111, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0108, 1, 0, 2'b11, 16'h0102, 16'h2222, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0108, 1, 0, 2'b01, 16'h0104, 16'h3333, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0108, 1, 0, 2'b10, 16'h0106, 16'h4444, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0108, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        // concurrent push/pop at DEPTH-1, pointers wrap, order preserved
        vecs.push_back('{1'b1, 16'h0200, 16'hA0A0, 2'b11, 1'b0, 16'h0000, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 16'h0202, 16'hA1A1, 2'b11, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0200, 16'hA0A0, 0});
        vecs.push_back('{1'b1, 16'h0204, 16'hA2A2, 2'b11, 1'b0, 16'h0000, 1, 0, 2'b00, 16'h0200, 16'hA0A0, 0});
        vecs.push_back('{1'b1, 16'h0206, 16'hA3A3, 2'b11, 1'b1, 16'h0000, 1, 0, 2'b11, 16'h0200, 16'hA0A0, 0});
        vecs.push_back('{1'b1, 16'h0208, 16'hA4A4, 2'b11, 1'b1, 16'h0000, 1, 0, 2'b11, 16'h0202, 16'hA1A1, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 0, 2'b11, 16'h0204, 16'hA2A2, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 0, 2'b11, 16'h0206, 16'hA3A3, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 0, 2'b11, 16'h0208, 16'hA4A4, 0});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1, 1, 2'b00, 16'h0000, 16'h0000, 0});

        // reset state
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_outs("reset", 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].dr, vecs[i].ld);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_empty,
                          vecs[i].e_wr_en, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_haz);
        end

        // reset asserted mid-drain with three stores queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 16'h0300 + 16'(2 * i), 16'hC000 + 16'(i), 2'b11, 1'b0, 16'h0302);
        end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0302);
        #1 check_outs("pre_rst", 1, 0, 2'b11, 16'h0300, 16'hC000, 1);
        #1 rst_n = 1'b0;
        #1 check_outs("in_rst", 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0400, 16'h7777, 2'b11, 1'b1, 16'h0302);
        #1 check_outs("post_rst", 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0302);
        #1 check_outs("first_acc", 1, 0, 2'b11, 16'h0400, 16'h7777, 0);
        @(negedge clk);
        #1 check_outs("drained", 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
        repeat (2) begin
            @(negedge clk);
            #1 check_outs("quiet", 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
